crc8_engine_scheduler: RTL and testbench
========================================

# crc8_engine_scheduler

Shares one bit-serial CRC-8 engine between two requesters, the UART transmit path (`tx_*`) and the UART receive path (`rx_*`). Each channel keeps its own running CRC context. The block arbitrates byte requests round-robin, sequences the engine through 8 shift steps per byte, and writes the result back to the owning channel's context. It sits between the UART byte interfaces and the frame logic that appends or checks the CRC byte.

## Interface
- `POLYNOMIAL`, default 8'h07, generator polynomial x^8+x^2+x+1 (implicit x^8).
- `INIT`, default 8'h00, context value after reset or clear.
- `clk` input 1: single clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `tx_clear` input 1: one-cycle pulse that sets the tx context to `INIT`.
- `tx_valid` input 1: tx byte request.
- `tx_data` input 8: tx byte; must be stable while `tx_valid` is high.
- `tx_ready` output 1: high when a tx byte is accepted this cycle.
- `tx_done` output 1: one-cycle pulse when the tx context has been updated.
- `tx_crc` output 8: current tx context.
- `rx_clear`, `rx_valid`, `rx_data`, `rx_ready`, `rx_done`, `rx_crc`: same as the tx ports, for the rx channel.
- `busy` output 1: high while the engine is in SHIFT.
- `rx_match` output 1: CRC residue check; see Configuration.

## Operation
- FSM states are IDLE and SHIFT.
- **Arbitration in IDLE (combinational):**
  - If only one channel has `valid`, that channel is selected.
  - If both have `valid`, the channel not served last is selected.
  - `last_served` resets to rx, so tx wins the first tie.
  - `x_ready = (state==IDLE) & selected==x`.
  - At most one ready is high in any cycle. Ready is never high in SHIFT.
- **Handshake (`valid & ready`):**
  - `work <= ctx_x ^ data_x`, `owner <= x`, `cnt <= 0`, `last_served <= x`, state moves to SHIFT.
- **SHIFT:** each cycle
  - `work <= work[7] ? {work[6:0],1'b0}^POLYNOMIAL : {work[6:0],1'b0}`
  - `cnt++`
  - On the 8th shift (cnt==7), `ctx_owner <= next work`, `owner_done` pulses the following cycle, and state returns to IDLE.
- The algorithm is MSB-first, non-reflected, with no final XOR. Check value: CRC("123456789") = 0xF4.
- **Clear rules:**
  - `x_clear` in IDLE without a handshake on the same channel: `ctx_x <= INIT`.
  - `x_clear` in the same cycle as an `x` handshake: the byte is processed starting from `INIT` (clear first).
  - `x_clear` while `x` owns SHIFT: `ctx_x <= INIT`, an abort flag is set, write-back is suppressed and no `x_done` pulse is issued.
  - Clearing the non-owning channel during SHIFT takes effect immediately and does not disturb the in-flight byte.
- `tx_crc` and `rx_crc` reflect the registered contexts at all times.
- **Reset:**
  - Contexts go to `INIT`.
  - `work`, `cnt`, `owner` and abort flag go to 0.
  - State goes to IDLE; `last_served` goes to rx.
  - All done pulses, `busy` and `rx_match` go to 0.
  - Reset mid-SHIFT discards the byte, and no done pulse follows.

## Timing
- Handshake at edge E0; shifts occur at E1..E8; context is updated at E8.
- `x_done` is high in the cycle after E8; `busy` is high from after E0 through E8.
- IDLE is re-entered after E8, so the earliest next handshake is E9. Throughput is 1 byte per 9 cycles.
- `valid` may stay asserted across consecutive bytes. The requester advances its data only after a cycle in which its ready was high.
- When both channels stream continuously, grants alternate tx, rx, tx, … and each channel gets 1 byte per 18 cycles.
- Ready depends combinationally on both valids. There is no combinational path from any input to done or crc.

## Configuration
- Macro: `CRC_SCHED_CHECK_EN`.
- **Defined:**
  - `rx_match` is a register updated at each rx write-back to `(new rx ctx == 8'h00)`.
  - It is cleared to 0 by `rx_clear` and by reset.
  - A received frame with its appended CRC byte therefore yields `rx_match = 1`.
- **Undefined:** `rx_match` is tied to 0 and no compare logic is built. The port list is unchanged in both cases.

## Test plan
- **Single tx byte:** after reset, send tx 0x01 → `tx_done` 9 cycles after the handshake, `tx_crc` = 0x07, `rx_crc` stays 0x00.
- **Stream and check value:** tx streams "123456789" (0x31..0x39) → 9 done pulses 9 cycles apart; final `tx_crc` = 0xF4.
- **Contention:** tx and rx both hold valid continuously, both sending "123456789" → ready alternates tx first; both contexts end at 0xF4; handshakes are 9 cycles apart.
- **Residue check (macro defined):** rx sends "123456789" then 0xF4 → `rx_match` = 1. Repeat with `rx_clear` and a last byte of 0xF5 → `rx_match` = 0. With the macro undefined, `rx_match` stays 0 throughout.
- **Clear mid-operation:** `tx_clear` at cycle 4 of a tx SHIFT → no `tx_done`, `tx_crc` = 0x00, next tx handshake accepted at E9. Clear in the same cycle as a handshake of 0x01 → result 0x07.
- **Reset mid-operation:** assert `reset_n` low during SHIFT → all outputs 0 or `INIT` immediately, no done pulse after release, first tie after reset goes to tx.

Source files
------------

// File: rtl/crc8_engine_scheduler_if.sv
// Byte request/response bundle between the UART tx/rx paths and the shared CRC-8 engine.
interface crc8_engine_scheduler_if;
  logic       tx_clear;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic [7:0] tx_crc;
  logic       rx_clear;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_done;
  logic [7:0] rx_crc;
  logic       busy;
  logic       rx_match;

  modport master (
    output tx_clear, tx_valid, tx_data, rx_clear, rx_valid, rx_data,
    input  tx_ready, tx_done, tx_crc, rx_ready, rx_done, rx_crc, busy, rx_match
  );

  modport slave (
    input  tx_clear, tx_valid, tx_data, rx_clear, rx_valid, rx_data,
    output tx_ready, tx_done, tx_crc, rx_ready, rx_done, rx_crc, busy, rx_match
  );
endinterface

// File: rtl/crc8_engine_scheduler.sv
// One bit-serial CRC-8 engine shared round-robin by tx and rx, each with its own context.
// Optional residue compare on rx write-back: define CRC_SCHED_CHECK_EN.
module crc8_engine_scheduler #(
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter logic [7:0] INIT       = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset_n,
  crc8_engine_scheduler_if.slave  bus
);

  localparam int unsigned CRC_W = 8;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [CRC_W-1:0] work, work_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             owner, owner_next;
  logic             last_rx, last_rx_next;
  logic             abort, abort_next;
  logic             abort_now;
  logic [CRC_W-1:0] tx_ctx, tx_ctx_next;
  logic [CRC_W-1:0] rx_ctx, rx_ctx_next;
  logic             tx_done, tx_done_next;
  logic             rx_done, rx_done_next;
  logic             busy, busy_next;
  logic [CRC_W-1:0] shifted;
  logic             tx_grant_c, rx_grant_c;

  // Tie goes to the channel not served last; owner/last_rx encode rx as 1.
  assign tx_grant_c = (state == IDLE) & bus.tx_valid & (~bus.rx_valid | last_rx);
  assign rx_grant_c = (state == IDLE) & bus.rx_valid & ~tx_grant_c;

  assign shifted = {work[CRC_W-2:0], 1'b0} ^ (work[CRC_W-1] ? POLYNOMIAL : '0);

`ifdef CRC_SCHED_CHECK_EN
  logic match, match_next;
`endif

  always_comb begin
    state_next   = state;
    work_next    = work;
    cnt_next     = cnt;
    owner_next   = owner;
    last_rx_next = last_rx;
    abort_next   = abort;
    abort_now    = 1'b0;
    tx_ctx_next  = bus.tx_clear ? INIT : tx_ctx;
    rx_ctx_next  = bus.rx_clear ? INIT : rx_ctx;
    tx_done_next = 1'b0;
    rx_done_next = 1'b0;
    busy_next    = busy;
`ifdef CRC_SCHED_CHECK_EN
    match_next   = bus.rx_clear ? 1'b0 : match;
`endif
    case (state)
      IDLE: begin
        if (tx_grant_c | rx_grant_c) begin
          // Context is taken after any same-cycle clear, so clear wins first.
          work_next    = rx_grant_c ? (rx_ctx_next ^ bus.rx_data) : (tx_ctx_next ^ bus.tx_data);
          owner_next   = rx_grant_c;
          last_rx_next = rx_grant_c;
          cnt_next     = '0;
          abort_next   = 1'b0;
          busy_next    = 1'b1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        work_next  = shifted;
        cnt_next   = cnt + CNT_W'(1);
        abort_now  = abort | (owner ? bus.rx_clear : bus.tx_clear);
        abort_next = abort_now;
        if (cnt == CNT_LAST) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          abort_next = 1'b0;
          if (!abort_now) begin
            if (owner) begin
              rx_ctx_next  = shifted;
              rx_done_next = 1'b1;
`ifdef CRC_SCHED_CHECK_EN
              match_next   = (shifted == '0);
`endif
            end else begin
              tx_ctx_next  = shifted;
              tx_done_next = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      owner   <= 1'b0;
      last_rx <= 1'b1;
      abort   <= 1'b0;
      tx_ctx  <= INIT;
      rx_ctx  <= INIT;
      tx_done <= 1'b0;
      rx_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      work    <= work_next;
      cnt     <= cnt_next;
      owner   <= owner_next;
      last_rx <= last_rx_next;
      abort   <= abort_next;
      tx_ctx  <= tx_ctx_next;
      rx_ctx  <= rx_ctx_next;
      tx_done <= tx_done_next;
      rx_done <= rx_done_next;
      busy    <= busy_next;
    end
  end

`ifdef CRC_SCHED_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) match <= 1'b0;
    else          match <= match_next;
  end
  assign bus.rx_match = match;
`else
  assign bus.rx_match = 1'b0;
`endif

  assign bus.tx_ready = tx_grant_c;
  assign bus.rx_ready = rx_grant_c;
  assign bus.tx_done  = tx_done;
  assign bus.rx_done  = rx_done;
  assign bus.tx_crc   = tx_ctx;
  assign bus.rx_crc   = rx_ctx;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_crc8_engine_scheduler.sv
// Randomized and directed bench for crc8_engine_scheduler against a transaction-level model.
module tb_crc8_engine_scheduler;

  localparam logic [7:0] POLY   = 8'h07;
  localparam logic [7:0] INIT_V = 8'h00;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  crc8_engine_scheduler_if bus ();

  crc8_engine_scheduler #(.POLYNOMIAL(POLY), .INIT(INIT_V)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       tx_clr_req = 1'b0;
  logic       rx_clr_req = 1'b0;

  // Model: byte CRC computed whole, engine occupancy as a countdown.
  logic [7:0] m_ctx[2];
  logic       m_done[2];
  logic [7:0] m_result;
  int         m_rem, m_owner, m_last;
  logic       m_abort, m_match;

  int  tx_done_n, rx_done_n, last_tx_cyc;
  bit  gap_en = 0;
  logic g_tx_rdy, g_rx_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Remainder of (crc ^ data) * x^8 divided by the generator, by long division.
  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
    logic [15:0] v;
    logic [15:0] g;
    v = {c ^ d, 8'h00};
    g = {7'h00, 1'b1, POLY};
    for (int i = 15; i >= 8; i--)
      if (v[i]) v = v ^ (g << (i - 8));
    return v[7:0];
  endfunction

  task automatic model_reset();
    m_ctx[0] = INIT_V; m_ctx[1] = INIT_V;
    m_done[0] = 1'b0;  m_done[1] = 1'b0;
    m_result = 8'h00; m_rem = 0; m_owner = 0; m_last = 1;
    m_abort = 1'b0; m_match = 1'b0;
  endtask

  task automatic step();
    logic [7:0] dat[2];
    logic       vld[2];
    logic       clr[2];
    int         sel;
    @(negedge clk);
    chk("tx_crc", 32'(bus.tx_crc), 32'(m_ctx[0]));
    chk("rx_crc", 32'(bus.rx_crc), 32'(m_ctx[1]));
    chk("tx_done", 32'(bus.tx_done), 32'(m_done[0]));
    chk("rx_done", 32'(bus.rx_done), 32'(m_done[1]));
    chk("busy", 32'(bus.busy), 32'(m_rem != 0));
    chk("rx_match", 32'(bus.rx_match), 32'(m_match));
    if (bus.tx_done) begin
      if (gap_en && tx_done_n > 0) chk("tx_done_gap", 32'(cyc - last_tx_cyc), 32'd9);
      last_tx_cyc = cyc;
      tx_done_n++;
    end
    if (bus.rx_done) rx_done_n++;

    vld[0] = tx_q.size() > 0;
    vld[1] = rx_q.size() > 0;
    dat[0] = vld[0] ? tx_q[0] : 8'($urandom);
    dat[1] = vld[1] ? rx_q[0] : 8'($urandom);
    clr[0] = tx_clr_req;
    clr[1] = rx_clr_req;
    tx_clr_req = 1'b0;
    rx_clr_req = 1'b0;
    bus.tx_valid = vld[0]; bus.tx_data = dat[0]; bus.tx_clear = clr[0];
    bus.rx_valid = vld[1]; bus.rx_data = dat[1]; bus.rx_clear = clr[1];
    #1;
    sel = -1;
    if (m_rem == 0) begin
      if (vld[0] && vld[1]) sel = (m_last == 1) ? 0 : 1;
      else if (vld[0])      sel = 0;
      else if (vld[1])      sel = 1;
    end
    g_tx_rdy = bus.tx_ready;
    g_rx_rdy = bus.rx_ready;
    chk("tx_ready", 32'(bus.tx_ready), 32'(sel == 0));
    chk("rx_ready", 32'(bus.rx_ready), 32'(sel == 1));
    if (bus.tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
    if (bus.rx_ready && rx_q.size() > 0) void'(rx_q.pop_front());

    m_done[0] = 1'b0; m_done[1] = 1'b0;
    for (int c = 0; c < 2; c++) if (clr[c]) m_ctx[c] = INIT_V;
`ifdef CRC_SCHED_CHECK_EN
    if (clr[1]) m_match = 1'b0;
`endif
    if (m_rem == 0) begin
      if (sel >= 0) begin
        m_result = crc_byte(m_ctx[sel], dat[sel]);
        m_owner = sel; m_last = sel; m_abort = 1'b0; m_rem = 8;
      end
    end else begin
      if (clr[m_owner]) m_abort = 1'b1;
      m_rem--;
      if (m_rem == 0 && !m_abort) begin
        m_ctx[m_owner] = m_result;
        m_done[m_owner] = 1'b1;
`ifdef CRC_SCHED_CHECK_EN
        if (m_owner == 1) m_match = (m_result == 8'h00);
`endif
      end
    end
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((tx_q.size() > 0 || rx_q.size() > 0 || m_rem != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < max_cyc), 32'd1);
    step();
    step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.tx_valid = 1'b0; bus.rx_valid = 1'b0;
    bus.tx_clear = 1'b0; bus.rx_clear = 1'b0;
    #1;
    chk("rst_tx_crc", 32'(bus.tx_crc), 32'(INIT_V));
    chk("rst_rx_crc", 32'(bus.rx_crc), 32'(INIT_V));
    chk("rst_tx_done", 32'(bus.tx_done), 32'd0);
    chk("rst_rx_done", 32'(bus.rx_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rx_match", 32'(bus.rx_match), 32'd0);
    model_reset();
    tx_q.delete(); rx_q.delete();
    tx_clr_req = 1'b0; rx_clr_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push_check_string(input bit to_rx);
    for (int i = 0; i < 9; i++) begin
      if (to_rx) rx_q.push_back(8'h31 + 8'(i));
      else       tx_q.push_back(8'h31 + 8'(i));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.tx_valid = 1'b0; bus.rx_valid = 1'b0;
    bus.tx_clear = 1'b0; bus.rx_clear = 1'b0;
    bus.tx_data = 8'h00; bus.rx_data = 8'h00;
    model_reset();
    apply_reset();

    // Single tx byte
    tx_q.push_back(8'h01);
    drain(50);
    chk("single_tx_crc", 32'(bus.tx_crc), 32'h07);
    chk("single_rx_crc", 32'(bus.rx_crc), 32'h00);

    // Streamed check string, with clear in the same cycle as the first handshake
    tx_done_n = 0; gap_en = 1;
    tx_clr_req = 1'b1;
    push_check_string(0);
    drain(200);
    gap_en = 0;
    chk("stream_tx_crc", 32'(bus.tx_crc), 32'hF4);
    chk("stream_done_count", 32'(tx_done_n), 32'd9);

    // Contention after reset: tx wins the first tie
    apply_reset();
    push_check_string(0);
    push_check_string(1);
    step();
    chk("first_tie_tx", 32'(g_tx_rdy), 32'd1);
    drain(400);
    chk("contend_tx_crc", 32'(bus.tx_crc), 32'hF4);
    chk("contend_rx_crc", 32'(bus.rx_crc), 32'hF4);

    // Residue check
    rx_clr_req = 1'b1;
    push_check_string(1);
    rx_q.push_back(8'hF4);
`ifdef CRC_SCHED_CHECK_EN
    drain(200);
    chk("residue_good", 32'(bus.rx_match), 32'd1);
`else
    drain(200);
    chk("residue_off", 32'(bus.rx_match), 32'd0);
`endif
    rx_clr_req = 1'b1;
    push_check_string(1);
    rx_q.push_back(8'hF5);
    drain(200);
    chk("residue_bad", 32'(bus.rx_match), 32'd0);

    // Clear of the owning channel mid-SHIFT
    tx_done_n = 0;
    tx_q.push_back(8'h01);
    step();
    for (int i = 0; i < 4; i++) step();
    tx_clr_req = 1'b1;
    drain(50);
    chk("abort_no_done", 32'(tx_done_n), 32'd0);
    chk("abort_tx_crc", 32'(bus.tx_crc), 32'h00);
    tx_q.push_back(8'h55);
    drain(50);
    tx_clr_req = 1'b1;
    tx_q.push_back(8'h01);
    drain(50);
    chk("clear_with_hs", 32'(bus.tx_crc), 32'h07);

    // Randomized traffic and clears
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && tx_q.size() < 2) tx_q.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0 && rx_q.size() < 2) rx_q.push_back(8'($urandom));
      if ($urandom_range(0, 24) == 0) tx_clr_req = 1'b1;
      if ($urandom_range(0, 24) == 0) rx_clr_req = 1'b1;
      step();
    end
    drain(400);

    // Reset mid-SHIFT discards the byte
    tx_done_n = 0;
    tx_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) step();
    apply_reset();
    for (int i = 0; i < 12; i++) step();
    chk("reset_no_done", 32'(tx_done_n), 32'd0);
    tx_q.push_back(8'h3C);
    rx_q.push_back(8'hC3);
    step();
    chk("reset_tie_tx", 32'(g_tx_rdy), 32'd1);
    chk("reset_tie_rx", 32'(g_rx_rdy), 32'd0);
    drain(100);
    chk("reset_pair_tx", 32'(bus.tx_crc), 32'(crc_byte(INIT_V, 8'h3C)));
    chk("reset_pair_rx", 32'(bus.rx_crc), 32'(crc_byte(INIT_V, 8'hC3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
